// File: rtl/dds_multi_channel.sv
// Multi-channel DDS: one swept or constant phase accumulator drives NCH waveform generators (saw/square/tri/DC).
// Latency 2 clocks from accumulator to Data; free-running and never stalls, so there is no backpressure.
module dds_multi_channel #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 12,
    parameter int DATA_W  = 14,
    parameter int NCH     = 2
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Cfg_Load,
    input  logic                    Phase_Clr,
    input  logic [ACC_W-1:0]        Fword,
    input  logic [ACC_W-1:0]        Fstep,
    input  logic [ACC_W-1:0]        Fstop,
    input  logic                    Sweep_En,
    input  logic [NCH*PHASE_W-1:0]  Pword,
    input  logic [NCH*2-1:0]        Mode_Sel,
    input  logic [PHASE_W-1:0]      Duty,
    output logic [NCH*DATA_W-1:0]   Data,
    output logic                    Data_Valid,
    output logic                    Sweep_Active,
    output logic                    Sweep_Done,
    output logic                    Wrap
);

    localparam int S = DATA_W - PHASE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       fcur;
    logic [ACC_W-1:0]       fcur_nxt;
    logic [ACC_W-1:0]       fstep_q;
    logic [ACC_W-1:0]       fstop_q;
    logic [NCH*PHASE_W-1:0] pword_q;
    logic [NCH*2-1:0]       mode_q;
    logic [PHASE_W-1:0]     duty_q;
    logic [ACC_W:0]         acc_sum;
    logic [ACC_W:0]         sweep_sum;
    logic                   sweep_hit;
    logic                   load_sweep;
    logic                   done_nxt;
    logic                   sweep_active_c;
    logic                   done_q;
    logic                   wrap_q;

    logic [PHASE_W-1:0]     ph1 [NCH];
    logic [NCH*2-1:0]       mode1;
    logic [PHASE_W-1:0]     duty1;
    logic                   vld1;
    logic [NCH*DATA_W-1:0]  data_q;
    logic                   vld2;

    assign acc_sum    = {1'b0, acc} + {1'b0, fcur};
    assign sweep_sum  = {1'b0, fcur} + {1'b0, fstep_q};
    // Carry-out of the sweep add counts as reaching Fstop, so a huge step cannot wrap past it.
    assign sweep_hit  = sweep_sum[ACC_W] || (sweep_sum[ACC_W-1:0] >= fstop_q);
    assign load_sweep = Sweep_En && (Fstep != '0) && (Fword < Fstop);

    // FSM: state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= ST_IDLE;
            fcur   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            fcur   <= fcur_nxt;
            done_q <= done_nxt;
        end
    end

    // FSM: next state; a load always wins and restarts any sweep in progress
    always_comb begin
        state_nxt = state;
        fcur_nxt  = fcur;
        done_nxt  = 1'b0;
        if (Cfg_Load) begin
            state_nxt = load_sweep ? ST_SWEEP : ST_RUN;
            fcur_nxt  = Fword;
        end else if (state == ST_SWEEP) begin
            if (sweep_hit) begin
                state_nxt = ST_RUN;
                fcur_nxt  = fstop_q;
                done_nxt  = 1'b1;
            end else begin
                fcur_nxt  = sweep_sum[ACC_W-1:0];
            end
        end
    end

    // FSM: outputs
    always_comb begin
        sweep_active_c = 1'b0;
        if (state == ST_SWEEP) begin
            sweep_active_c = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fstep_q <= '0;
            fstop_q <= '0;
            pword_q <= '0;
            mode_q  <= '0;
            duty_q  <= '0;
        end else if (Cfg_Load) begin
            fstep_q <= Fstep;
            fstop_q <= Fstop;
            pword_q <= Pword;
            mode_q  <= Mode_Sel;
            duty_q  <= Duty;
        end
    end

    // Accumulator keeps running across loads for phase continuity; only Phase_Clr or IDLE zero it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc    <= '0;
            wrap_q <= 1'b0;
        end else if (state == ST_IDLE || Phase_Clr) begin
            acc    <= '0;
            wrap_q <= 1'b0;
        end else begin
            acc    <= acc_sum[ACC_W-1:0];
            wrap_q <= acc_sum[ACC_W];
        end
    end

    function automatic logic [DATA_W-1:0] wave(
        input logic [1:0]         m,
        input logic [PHASE_W-1:0] ph,
        input logic [PHASE_W-1:0] thr
    );
        logic [PHASE_W-2:0] t;
        logic [DATA_W-1:0]  w;
        t = ph[PHASE_W-1] ? ~ph[PHASE_W-2:0] : ph[PHASE_W-2:0];
        w = '0;
        case (m)
            2'd0:    w = DATA_W'(ph) << S;
            2'd1:    w = (ph < thr) ? '1 : '0;
            2'd2:    w = DATA_W'(t) << (S + 1);
            default: w = {1'b1, {(DATA_W-1){1'b0}}};
        endcase
        return w;
    endfunction

    // Mode and duty travel with the phase so a config change lines up with the sample it belongs to.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                ph1[k] <= '0;
            end
            mode1  <= '0;
            duty1  <= '0;
            vld1   <= 1'b0;
            data_q <= '0;
            vld2   <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                ph1[k] <= acc[ACC_W-1 -: PHASE_W] + pword_q[k*PHASE_W +: PHASE_W];
                data_q[k*DATA_W +: DATA_W] <= wave(mode1[k*2 +: 2], ph1[k], duty1);
            end
            mode1  <= mode_q;
            duty1  <= duty_q;
            vld1   <= (state != ST_IDLE);
            vld2   <= vld1;
        end
    end

    assign Data         = data_q;
    assign Data_Valid   = vld2;
    assign Sweep_Active = sweep_active_c;
    assign Sweep_Done   = done_q;
    assign Wrap         = wrap_q;

endmodule

// File: tb/tb_dds_multi_channel.sv
// Directed bench for dds_multi_channel: sawtooth, square, triangle, DC, sweep, reset and phase-clear cases.
module tb_dds_multi_channel;

    localparam int ACC_W   = 32;
    localparam int PHASE_W = 12;
    localparam int DATA_W  = 14;
    localparam int NCH     = 2;

    logic                   Clk;
    logic                   Reset_n;
    logic                   Cfg_Load;
    logic                   Phase_Clr;
    logic [ACC_W-1:0]       Fword;
    logic [ACC_W-1:0]       Fstep;
    logic [ACC_W-1:0]       Fstop;
    logic                   Sweep_En;
    logic [NCH*PHASE_W-1:0] Pword;
    logic [NCH*2-1:0]       Mode_Sel;
    logic [PHASE_W-1:0]     Duty;
    logic [NCH*DATA_W-1:0]  Data;
    logic                   Data_Valid;
    logic                   Sweep_Active;
    logic                   Sweep_Done;
    logic                   Wrap;

    logic [DATA_W-1:0]      ch0;
    logic [DATA_W-1:0]      ch1;

    int n_checks = 0;
    int n_pass   = 0;

    assign ch0 = Data[DATA_W-1:0];
    assign ch1 = Data[2*DATA_W-1:DATA_W];

    dds_multi_channel #(
        .ACC_W(ACC_W), .PHASE_W(PHASE_W), .DATA_W(DATA_W), .NCH(NCH)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Cfg_Load(Cfg_Load), .Phase_Clr(Phase_Clr),
        .Fword(Fword), .Fstep(Fstep), .Fstop(Fstop), .Sweep_En(Sweep_En),
        .Pword(Pword), .Mode_Sel(Mode_Sel), .Duty(Duty), .Data(Data),
        .Data_Valid(Data_Valid), .Sweep_Active(Sweep_Active),
        .Sweep_Done(Sweep_Done), .Wrap(Wrap)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n   = 1'b0;
        Cfg_Load  = 1'b0;
        Phase_Clr = 1'b0;
        repeat (2) step();
        Reset_n = 1'b1;
        step();
    endtask

    task automatic load(input logic [31:0] fw, input logic [31:0] fs, input logic [31:0] fe,
                        input logic sw, input logic [23:0] pw, input logic [3:0] md,
                        input logic [11:0] dt);
        Fword    = fw;
        Fstep    = fs;
        Fstop    = fe;
        Sweep_En = sw;
        Pword    = pw;
        Mode_Sel = md;
        Duty     = dt;
        Cfg_Load = 1'b1;
        step();
        Cfg_Load = 1'b0;
    endtask

    // Triangle expectation written as a fold at the half-period point.
    function automatic int tri_exp(input int ph);
        return (ph < 2048) ? ph * 8 : (4095 - ph) * 8;
    endfunction

    initial begin
        int first_wrap;
        int second_wrap;
        int n_wrap;
        int n_done;
        int n_vld;

        Reset_n   = 1'b0;
        Cfg_Load  = 1'b0;
        Phase_Clr = 1'b0;
        Fword     = '0;
        Fstep     = '0;
        Fstop     = '0;
        Sweep_En  = 1'b0;
        Pword     = '0;
        Mode_Sel  = '0;
        Duty      = '0;
        repeat (2) step();

        check("rst_data",  Data,         0);
        check("rst_vld",   Data_Valid,   0);
        check("rst_swact", Sweep_Active, 0);
        check("rst_done",  Sweep_Done,   0);
        check("rst_wrap",  Wrap,         0);

        // Sawtooth ch0, one phase LSB per clock
        Reset_n = 1'b1;
        step();
        load(32'h0010_0000, 0, 0, 1'b0, 24'd0, 4'b0000, 12'd0);
        check("saw_vld_e0", Data_Valid, 0);
        step();
        check("saw_vld_e1", Data_Valid, 0);
        step();
        check("saw_vld_e2", Data_Valid, 1);
        check("saw_first",  ch0, 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("saw_seq", ch0, 4 * k);
        end
        repeat (5) step();

        // Frequency change in RUN: ramp continues from the same phase, then steps by 3
        Fword    = 32'h0030_0000;
        Mode_Sel = 4'b1100;
        Cfg_Load = 1'b1;
        step();
        Cfg_Load = 1'b0;
        check("cont_m0", ch0, 36);
        step();
        check("cont_m1", ch0, 40);
        step();
        check("cont_m2", ch0, 44);
        check("dc_ch1",  ch1, 8192);
        step();
        check("cont_m3", ch0, 56);
        step();
        check("cont_m4", ch0, 68);

        // Phase clear together with load
        Phase_Clr = 1'b1;
        Fword     = 32'h0010_0000;
        Pword     = {12'd0, 12'd100};
        Mode_Sel  = 4'b0000;
        Cfg_Load  = 1'b1;
        step();
        Phase_Clr = 1'b0;
        Cfg_Load  = 1'b0;
        check("clr_wrap", Wrap, 0);
        step();
        step();
        check("clr_ch0_p2", ch0, 400);
        check("clr_ch1_p2", ch1, 0);
        step();
        check("clr_ch0_p3", ch0, 404);
        check("clr_ch1_p3", ch1, 4);

        // Triangle on ch1 with a quarter-period offset, sawtooth on ch0
        do_reset();
        load(32'h0010_0000, 0, 0, 1'b0, {12'd1024, 12'd0}, 4'b1000, 12'd0);
        step();
        step();
        check("tri_vld", Data_Valid, 1);
        for (int k = 0; k <= 1100; k++) begin
            check("tri_ch1", ch1, tri_exp((1024 + k) % 4096));
            check("tri_ch0", ch0, (4 * k) % 16384);
            step();
        end

        // Square on ch0 at 50% duty, 256 samples per period
        do_reset();
        load(32'h0100_0000, 0, 0, 1'b0, 24'd0, 4'b0001, 12'd2048);
        first_wrap  = -1;
        second_wrap = -1;
        n_wrap      = 0;
        for (int e = 1; e <= 520; e++) begin
            step();
            if (Wrap) begin
                n_wrap++;
                if (first_wrap < 0) first_wrap = e;
                else if (second_wrap < 0) second_wrap = e;
            end
            if (e >= 2) begin
                check("sq_ch0", ch0, (((16 * (e - 2)) % 4096) < 2048) ? 16383 : 0);
            end
        end
        check("wrap_first",  first_wrap, 256);
        check("wrap_period", second_wrap - first_wrap, 256);
        check("wrap_count",  n_wrap, 2);

        // Linear sweep 0x100 -> 0x500 in steps of 0x100
        do_reset();
        load(32'h100, 32'h100, 32'h500, 1'b1, 24'd0, 4'b0000, 12'd0);
        check("sw_active0", Sweep_Active, 1);
        check("sw_fcur0",   dut.fcur, 32'h100);
        n_done = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("sw_fcur",   dut.fcur, 32'h100 * (i + 1));
            check("sw_done",   Sweep_Done, (i == 4) ? 1 : 0);
            check("sw_active", Sweep_Active, (i < 4) ? 1 : 0);
            if (Sweep_Done) n_done++;
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (Sweep_Done) n_done++;
        end
        check("sw_done_cnt", n_done, 1);
        check("sw_fcur_end", dut.fcur, 32'h500);

        // Reset in the middle of a long sweep
        load(32'h100, 32'h1, 32'hFFFF_0000, 1'b1, {12'd7, 12'd5}, 4'b0000, 12'd0);
        repeat (3) step();
        check("mid_vld_pre", Data_Valid, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("mid_data",  Data,         0);
        check("mid_vld",   Data_Valid,   0);
        check("mid_swact", Sweep_Active, 0);
        check("mid_done",  Sweep_Done,   0);
        check("mid_wrap",  Wrap,         0);
        step();
        Reset_n = 1'b1;
        n_vld  = 0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (Data_Valid) n_vld++;
            if (Sweep_Done || Sweep_Active) n_done++;
        end
        check("post_rst_vld",   n_vld, 0);
        check("post_rst_sweep", n_done, 0);
        load(32'h0010_0000, 0, 0, 1'b0, {12'd0, 12'd5}, 4'b0000, 12'd0);
        step();
        step();
        check("reload_vld", Data_Valid, 1);
        check("reload_ch0", ch0, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dds_multi_channel.md
DDS_MULTI_CHANNEL -- requirements
Module: dds_multi_channel

Interface
REQ-001 SHALL have parameter ACC_W, default 32, phase-accumulator width.
REQ-002 SHALL have parameter PHASE_W, default 12, truncated phase width (PHASE_W <= ACC_W).
REQ-003 SHALL have parameter DATA_W, default 14, sample width per channel (DATA_W >= PHASE_W).
REQ-004 SHALL have parameter NCH, default 2, channel count sharing one accumulator.
REQ-005 SHALL have port Clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port Cfg_Load  input  1  strobe: capture all configuration inputs this edge.
REQ-008 SHALL have port Phase_Clr  input  1  strobe: clear accumulator this edge.
REQ-009 SHALL have port Fword  input  ACC_W  start/constant frequency word.
REQ-010 SHALL have port Fstep  input  ACC_W  sweep increment per clock.
REQ-011 SHALL have port Fstop  input  ACC_W  sweep end frequency word.
REQ-012 SHALL have port Sweep_En  input  1  select sweep on load.
REQ-013 SHALL have port Pword  input  NCH*PHASE_W  per-channel phase offset, channel k at [k*PHASE_W +: PHASE_W].
REQ-014 SHALL have port Mode_Sel  input  NCH*2  per-channel waveform: 0 sawtooth, 1 square, 2 triangle, 3 DC midscale.
REQ-015 SHALL have port Duty  input  PHASE_W  square threshold, shared.
REQ-016 SHALL have port Data  output  NCH*DATA_W  registered samples, channel k at [k*DATA_W +: DATA_W].
REQ-017 SHALL have port Data_Valid  output  1  Data holds a generated sample.
REQ-018 SHALL have port Sweep_Active  output  1  high while in SWEEP.
REQ-019 SHALL have port Sweep_Done  output  1  one-cycle pulse when sweep reaches Fstop.
REQ-020 SHALL have port Wrap  output  1  one-cycle pulse on the edge after accumulator carry-out.

Function
REQ-021 SHALL hold configuration in shadow registers updated only on edges with Cfg_Load=1; inputs otherwise ignored.
REQ-022 SHALL implement FSM IDLE/RUN/SWEEP; IDLE after reset; Cfg_Load from any state -> SWEEP if Sweep_En=1, Fstep!=0 and Fword<Fstop, else RUN; load sets Fcur=Fword.
REQ-023 SHALL in IDLE hold accumulator Acc at 0; in RUN/SWEEP, Acc <= Acc+Fcur mod 2^ACC_W every edge, using Fcur value before this edge.
REQ-024 SHALL in SWEEP compute Fcur+Fstep each edge; if sum>=Fstop or carry-out: Fcur<=Fstop, state->RUN, Sweep_Done=1 next cycle, else Fcur<=sum.
REQ-025 SHALL keep phase continuity on Cfg_Load in RUN/SWEEP (Acc not cleared); Cfg_Load mid-sweep restarts sweep from new Fword, no Sweep_Done.
REQ-026 SHALL on Phase_Clr set Acc<=0 regardless of state; Phase_Clr with Cfg_Load applies both; Phase_Clr in IDLE no effect.
REQ-027 SHALL compute ph_k = Acc[ACC_W-1 -: PHASE_W] + Pword_k mod 2^PHASE_W, registered (stage 1).
REQ-028 SHALL register waveform (stage 2), S=DATA_W-PHASE_W: sawtooth ph<<S; square (ph<Duty)?2^DATA_W-1:0; triangle t<<(S+1), t=ph[PHASE_W-2:0] if ph MSB=0 else its bitwise inverse; DC 2^(DATA_W-1).
REQ-029 SHALL give latency 2: Data at edge n+2 derives from Acc after edge n; first Data_Valid sample after load from IDLE uses Acc=0 (ph=Pword_k).
REQ-030 SHALL drive Data_Valid via 2-stage pipeline of (state!=IDLE); Mode_Sel/Duty/Pword changes take effect with same 2-cycle alignment.
REQ-031 SHALL pulse Wrap only for accumulator carry, not for Phase_Clr.

Reset
REQ-032 SHALL on Reset_n=0 asynchronously: state IDLE, Acc=0, Fcur=0, shadow registers 0, pipeline cleared, Data=0, Data_Valid=0, Sweep_Active=0, Sweep_Done=0, Wrap=0.
REQ-033 SHALL on reset mid-sweep abandon the sweep, no Sweep_Done, remain IDLE until next Cfg_Load.

Verification (defaults ACC_W=32, PHASE_W=12, DATA_W=14, NCH=2)
REQ-034 SHALL cover: reset, Cfg_Load Fword=0x0010_0000, ch0 sawtooth Pword0=0 -> Data_Valid rises 2 edges after load, ch0 = 0,4,8,12,...
REQ-035 SHALL cover: ch0 square Duty=2048, Fword=0x0100_0000 -> 128 samples of 16383 then 128 of 0, Wrap every 256 cycles.
REQ-036 SHALL cover: ch1 triangle Pword1=1024, Fword=0x0010_0000 -> first valid sample 8192, ph=2048 gives 16376, ch1 tracks ch0 at fixed offset.
REQ-037 SHALL cover: Sweep_En=1, Fword=0x100, Fstep=0x100, Fstop=0x500 -> Fcur 0x100..0x500 over 4 edges, single Sweep_Done pulse, Sweep_Active low after.
REQ-038 SHALL cover: Reset_n low mid-sweep -> all outputs 0 immediately, no Data_Valid until new Cfg_Load.
REQ-039 SHALL cover: Cfg_Load with new Fword in RUN -> no phase discontinuity; same with Phase_Clr -> Acc=0, sample 2 edges later = Pword-based value.
